// File: rtl/sockit_ghrd_button_svc.sv
// sockit_ghrd_button_svc
//   Hardware service loop for the 4-bit edge-capture button PIO. After reset
//   it programs the slave irq_mask, then on each slave interrupt it reads
//   edge_capture, clears it, reads the button levels and queues an
//   {edges, levels} event for fabric consumers.
//
//   Build option: define BUTTON_SVC_HOLDOFF_EN to add a HOLD state after each
//   queued event that ignores irq for HOLDOFF_CYCLES cycles (debounce lockout).
//   Edges that arrive during HOLD stay latched in the slave and are serviced
//   once HOLD ends.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   avm_address/read/write/
//   avm_writedata                 registered Avalon-MM master command
//   avm_readdata, avm_waitrequest Avalon-MM slave response / stall
//   irq                           slave interrupt (level)
//   evt_valid/ready/edges/levels  event FIFO head, popped on valid && ready
//   overflow, ovf_clr             sticky event-dropped flag and its clear
//
// Timing (READ_LATENCY=1, no waitrequest): irq first high in cycle n gives
// evt_valid high in cycle n+8. irq goes through one register stage before the
// FSM looks at it.
module sockit_ghrd_button_svc #(
  parameter int               WIDTH          = 4,
  parameter int               FIFO_DEPTH     = 4,
  parameter int               READ_LATENCY   = 1,
  parameter logic [WIDTH-1:0] IRQ_MASK_INIT  = {WIDTH{1'b1}},
  parameter int               HOLDOFF_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest,
  input  logic             irq,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_levels,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_EDGE = 2'd3;

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_RD_EDGE,
    S_RD_EDGE_WAIT,
    S_WR_CLR,
    S_RD_DATA,
    S_RD_DATA_WAIT,
    S_PUSH
`ifdef BUTTON_SVC_HOLDOFF_EN
    , S_HOLD
`endif
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] levels;
  } evt_t;

  state_t           state, nxt;
  logic             irq_q;
  logic [1:0]       lat_cnt;
  logic             lat_done;
  logic             accept;
  logic [WIDTH-1:0] edges_q, levels_q;

  logic             rd_nx, wr_nx;
  logic [1:0]       addr_nx;
  logic [31:0]      wdata_nx;

  logic unused_rd_bits;
  assign unused_rd_bits = ^avm_readdata[31:WIDTH];

  // A command completes on the cycle it is presented and not stalled.
  assign accept   = (avm_read | avm_write) & ~avm_waitrequest;
  // Counts cycles spent in a *_WAIT state; read data is valid on the
  // READ_LATENCY-th cycle after the accept cycle.
  assign lat_done = (lat_cnt == 2'(READ_LATENCY - 1));

`ifdef BUTTON_SVC_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  logic [HW-1:0] hold_cnt;
  logic          hold_done;
  assign hold_done = (hold_cnt == HW'(HOLDOFF_CYCLES - 1));
`else
  // HOLDOFF_CYCLES only matters with the lockout compiled in.
  localparam int UNUSED_HOLDOFF = HOLDOFF_CYCLES;
`endif

  // ---------------- next state + next command ----------------
  always_comb begin
    nxt      = state;
    rd_nx    = 1'b0;
    wr_nx    = 1'b0;
    addr_nx  = '0;
    wdata_nx = '0;
    case (state)
      S_INIT:         if (accept) nxt = S_IDLE;
      S_IDLE:         if (irq_q) nxt = S_RD_EDGE;
      S_RD_EDGE:      if (accept) nxt = S_RD_EDGE_WAIT;
      S_RD_EDGE_WAIT: if (lat_done)
                        nxt = (avm_readdata[WIDTH-1:0] == '0) ? S_IDLE : S_WR_CLR;
      S_WR_CLR:       if (accept) nxt = S_RD_DATA;
      S_RD_DATA:      if (accept) nxt = S_RD_DATA_WAIT;
      S_RD_DATA_WAIT: if (lat_done) nxt = S_PUSH;
`ifdef BUTTON_SVC_HOLDOFF_EN
      S_PUSH:         nxt = S_HOLD;
      S_HOLD:         if (hold_done) nxt = S_IDLE;
`else
      S_PUSH:         nxt = S_IDLE;
`endif
      default:        nxt = S_INIT;
    endcase
    // The bus command is registered from the state being entered, so a
    // command state drives its command from its first cycle and keeps it
    // until the accept cycle moves the FSM on.
    case (nxt)
      S_INIT:    begin wr_nx = 1'b1; addr_nx = A_MASK; wdata_nx = 32'(IRQ_MASK_INIT); end
      S_RD_EDGE: begin rd_nx = 1'b1; addr_nx = A_EDGE; end
      S_WR_CLR:  begin wr_nx = 1'b1; addr_nx = A_EDGE; end
      S_RD_DATA: begin rd_nx = 1'b1; addr_nx = A_DATA; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_INIT;
      irq_q         <= 1'b0;
      lat_cnt       <= '0;
      edges_q       <= '0;
      levels_q      <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
    end else begin
      state         <= nxt;
      irq_q         <= irq;
      avm_read      <= rd_nx;
      avm_write     <= wr_nx;
      avm_address   <= addr_nx;
      avm_writedata <= wdata_nx;
      if ((state == S_RD_EDGE_WAIT || state == S_RD_DATA_WAIT) && !lat_done)
        lat_cnt <= lat_cnt + 2'd1;
      else
        lat_cnt <= '0;
      if (state == S_RD_EDGE_WAIT && lat_done) edges_q  <= avm_readdata[WIDTH-1:0];
      if (state == S_RD_DATA_WAIT && lat_done) levels_q <= avm_readdata[WIDTH-1:0];
    end
  end

`ifdef BUTTON_SVC_HOLDOFF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             hold_cnt <= '0;
    else if (state == S_HOLD) hold_cnt <= hold_cnt + HW'(1);
    else                      hold_cnt <= '0;
  end
`endif

  // ---------------- event FIFO ----------------
  evt_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push_req, push, pop, full;

  assign evt_valid  = (count != '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign pop        = evt_valid & evt_ready;
  assign push_req   = (state == S_PUSH);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push       = push_req & (~full | pop);
  assign evt_edges  = mem[rd_ptr].edges;
  assign evt_levels = mem[rd_ptr].levels;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{edges: edges_q, levels: levels_q};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      // A drop in the same cycle as a clear wins.
      if (push_req && !push) overflow <= 1'b1;
      else if (ovf_clr)      overflow <= 1'b0;
    end
  end

endmodule
